// File: rtl/sme_multi.sv
// sme_multi: parametrised string-matching engine.
//
// Buffers a streamed string and pattern, then searches for the leftmost match.
// Pattern metacharacters: '.' (any char), '^' (start or after space),
// '$' (end or at space), and a single '*' (any run of chars).
//
// Ports:
//   clk          clock, all state on rising edge
//   reset        asynchronous active-high reset
//   chardata     ASCII char, qualified by isstring/ispattern
//   isstring     chardata is the next string char
//   ispattern    chardata is the next pattern char
//   nocase       case-insensitive mode, sampled with the first pattern char
//   busy         high while searching; incoming chars are dropped
//   valid        one-cycle result strobe
//   match        match result, held until the next valid
//   match_index  leftmost match start, held until the next valid
module sme_multi #(
    parameter int unsigned STR_DEPTH = 32,
    parameter int unsigned PAT_DEPTH = 8,
    parameter int unsigned IDX_W     = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       chardata,
    input  logic             isstring,
    input  logic             ispattern,
    input  logic             nocase,
    output logic             busy,
    output logic             valid,
    output logic             match,
    output logic [IDX_W-1:0] match_index
);

    localparam int unsigned PW  = $clog2(PAT_DEPTH + 1);
    localparam int unsigned PIW = (PAT_DEPTH > 1) ? $clog2(PAT_DEPTH) : 1;

    localparam logic [IDX_W:0] StrMax = (IDX_W + 1)'(STR_DEPTH);
    localparam logic [IDX_W:0] SOne   = (IDX_W + 1)'(1);
    localparam logic [PW-1:0]  PatMax = PW'(PAT_DEPTH);
    localparam logic [PW-1:0]  POne   = PW'(1);

    localparam logic [7:0] ChSpace  = 8'h20;
    localparam logic [7:0] ChDollar = 8'h24;
    localparam logic [7:0] ChStar   = 8'h2A;
    localparam logic [7:0] ChDot    = 8'h2E;
    localparam logic [7:0] ChCaret  = 8'h5E;

    typedef enum logic [2:0] {StIdle, StRecvS, StRecvP, StSearch, StDone} state_e;

    state_e           state_q, state_d;
    logic [7:0]       str_q [STR_DEPTH];
    logic [7:0]       pat_q [PAT_DEPTH];
    logic [IDX_W:0]   slen_q, slen_d;
    logic [PW-1:0]    plen_q, plen_d;
    logic             nocase_q, nocase_d;
    logic [IDX_W:0]   s_q, s_d;          // candidate start
    logic [IDX_W:0]   pos_q, pos_d;      // current string position
    logic [PW-1:0]    p_q, p_d;          // current pattern position
    logic             star_seen_q, star_seen_d;
    logic [PW-1:0]    star_p_q, star_p_d;
    logic [IDX_W:0]   star_pos_q, star_pos_d;
    logic             match_q, match_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             str_we, pat_we, pat_take;
    logic [IDX_W-1:0] str_waddr;
    logic [PIW-1:0]   pat_waddr;
    logic [7:0]       pc, cur, prv;
    logic [IDX_W:0]   last_s;
    logic             chr_eq, step_ok, step_adv;

    function automatic logic [7:0] fold(input logic [7:0] c);
        fold = (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
    endfunction

    assign pc     = pat_q[p_q[PIW-1:0]];
    assign cur    = str_q[pos_q[IDX_W-1:0]];
    assign prv    = str_q[pos_q[IDX_W-1:0] - IDX_W'(1)];
    assign last_s = (slen_q == '0) ? '0 : slen_q - SOne;
    assign chr_eq = nocase_q ? (fold(pc) == fold(cur)) : (pc == cur);

    // Evaluate one pattern element against the current position.
    always_comb begin
        step_ok  = 1'b0;
        step_adv = 1'b0;
        case (pc)
            ChCaret:  step_ok = (pos_q == '0) || (prv == ChSpace);
            ChDollar: step_ok = (pos_q == slen_q) || (cur == ChSpace);
            ChStar:   step_ok = 1'b1;
            default: begin
                step_ok  = (pos_q < slen_q) && ((pc == ChDot) || chr_eq);
                step_adv = step_ok;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        slen_d      = slen_q;
        plen_d      = plen_q;
        nocase_d    = nocase_q;
        s_d         = s_q;
        pos_d       = pos_q;
        p_d         = p_q;
        star_seen_d = star_seen_q;
        star_p_d    = star_p_q;
        star_pos_d  = star_pos_q;
        match_d     = match_q;
        idx_d       = idx_q;
        str_we      = 1'b0;
        pat_we      = 1'b0;
        pat_take    = 1'b0;
        str_waddr   = slen_q[IDX_W-1:0];
        pat_waddr   = plen_q[PIW-1:0];

        unique case (state_q)
            StIdle, StDone: begin
                if (isstring) begin
                    state_d   = StRecvS;
                    str_we    = 1'b1;
                    str_waddr = '0;
                    slen_d    = SOne;
                    plen_d    = '0;
                end else if (ispattern) begin
                    // Pattern-only job: previous string is reused.
                    state_d   = StRecvP;
                    pat_we    = 1'b1;
                    pat_waddr = '0;
                    plen_d    = POne;
                    nocase_d  = nocase;
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StRecvS: begin
                if (isstring) begin
                    if (slen_q < StrMax) begin
                        str_we = 1'b1;
                        slen_d = slen_q + SOne;
                    end
                end else begin
                    state_d  = StRecvP;
                    pat_take = ispattern;
                end
            end
            StRecvP: begin
                if (ispattern) begin
                    pat_take = 1'b1;
                end else if (plen_q != '0) begin
                    state_d     = StSearch;
                    s_d         = '0;
                    pos_d       = '0;
                    p_d         = '0;
                    star_seen_d = 1'b0;
                end
            end
            StSearch: begin
                if (p_q == plen_q) begin
                    state_d = StDone;
                    match_d = 1'b1;
                    idx_d   = s_q[IDX_W-1:0];
                end else if (step_ok) begin
                    p_d = p_q + POne;
                    if (step_adv) begin
                        pos_d = pos_q + SOne;
                    end
                    if (pc == ChStar) begin
                        star_seen_d = 1'b1;
                        star_p_d    = p_q;
                        star_pos_d  = pos_q;
                    end
                end else if (star_seen_q) begin
                    // The chars consumed before '*' are fixed in count, so the
                    // suffix failing at every later offset means no later start
                    // can match either.
                    if (star_pos_q < slen_q) begin
                        star_pos_d = star_pos_q + SOne;
                        pos_d      = star_pos_q + SOne;
                        p_d        = star_p_q + POne;
                    end else begin
                        state_d = StDone;
                        match_d = 1'b0;
                        idx_d   = '0;
                    end
                end else if (s_q < last_s) begin
                    s_d   = s_q + SOne;
                    pos_d = s_q + SOne;
                    p_d   = '0;
                end else begin
                    state_d = StDone;
                    match_d = 1'b0;
                    idx_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (pat_take && plen_q < PatMax) begin
            pat_we = 1'b1;
            plen_d = plen_q + POne;
            if (plen_q == '0) begin
                nocase_d = nocase;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            slen_q      <= '0;
            plen_q      <= '0;
            nocase_q    <= 1'b0;
            s_q         <= '0;
            pos_q       <= '0;
            p_q         <= '0;
            star_seen_q <= 1'b0;
            star_p_q    <= '0;
            star_pos_q  <= '0;
            match_q     <= 1'b0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            slen_q      <= slen_d;
            plen_q      <= plen_d;
            nocase_q    <= nocase_d;
            s_q         <= s_d;
            pos_q       <= pos_d;
            p_q         <= p_d;
            star_seen_q <= star_seen_d;
            star_p_q    <= star_p_d;
            star_pos_q  <= star_pos_d;
            match_q     <= match_d;
            idx_q       <= idx_d;
        end
    end

    // Character buffers need no reset; the lengths qualify their contents.
    always_ff @(posedge clk) begin
        if (str_we) begin
            str_q[str_waddr] <= chardata;
        end
        if (pat_we) begin
            pat_q[pat_waddr] <= chardata;
        end
    end

    assign busy        = (state_q == StSearch);
    assign valid       = (state_q == StDone);
    assign match       = match_q;
    assign match_index = idx_q;

endmodule

// File: tb/tb_sme_multi.sv
module tb_sme_multi;

    localparam int unsigned STR_DEPTH = 32;
    localparam int unsigned PAT_DEPTH = 8;
    localparam int unsigned IDX_W     = 5;

    typedef byte unsigned bq_t[$];

    logic             clk;
    logic             reset;
    logic [7:0]       chardata;
    logic             isstring;
    logic             ispattern;
    logic             nocase;
    logic             busy;
    logic             valid;
    logic             match;
    logic [IDX_W-1:0] match_index;

    int errors;
    int checks;

    // Reference state: what the engine should currently hold.
    bq_t m_str;
    bq_t m_pat;
    bit  m_nocase;

    // Observation of the last job.
    bit               o_got;
    bit               o_match;
    bit               o_busy_edge;
    logic [IDX_W-1:0] o_idx;

    sme_multi #(
        .STR_DEPTH(STR_DEPTH),
        .PAT_DEPTH(PAT_DEPTH),
        .IDX_W    (IDX_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chardata   (chardata),
        .isstring   (isstring),
        .ispattern  (ispattern),
        .nocase     (nocase),
        .busy       (busy),
        .valid      (valid),
        .match      (match),
        .match_index(match_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // ---------------- reference model ----------------
    function automatic bit ceq(input byte unsigned a, input byte unsigned b);
        byte unsigned x = a;
        byte unsigned y = b;
        if (m_nocase) begin
            if (x >= 8'h41 && x <= 8'h5A) x = x + 8'd32;
            if (y >= 8'h41 && y <= 8'h5A) y = y + 8'd32;
        end
        return x == y;
    endfunction

    // Match star-free pattern slice [a,b) starting at pos; end position or -1.
    function automatic int seg(input int a, input int b, input int pos);
        int n = m_str.size();
        int p = pos;
        for (int i = a; i < b; i++) begin
            byte unsigned c = m_pat[i];
            if (c == 8'h5E) begin
                if (!(p == 0 || m_str[p-1] == 8'h20)) return -1;
            end else if (c == 8'h24) begin
                if (!(p == n || m_str[p] == 8'h20)) return -1;
            end else begin
                if (p >= n) return -1;
                if (c != 8'h2E && !ceq(c, m_str[p])) return -1;
                p++;
            end
        end
        return p;
    endfunction

    function automatic void model(output bit m, output int idx);
        int n    = m_str.size();
        int np   = m_pat.size();
        int star = -1;
        m   = 1'b0;
        idx = 0;
        foreach (m_pat[i]) if (m_pat[i] == 8'h2A) star = i;
        if (n == 0) begin
            m = 1'b1;
            foreach (m_pat[i]) if (!(m_pat[i] inside {8'h5E, 8'h24, 8'h2A})) m = 1'b0;
            return;
        end
        for (int s = 0; s < n; s++) begin
            if (star < 0) begin
                if (seg(0, np, s) >= 0) begin m = 1'b1; idx = s; return; end
            end else begin
                int e = seg(0, star, s);
                if (e >= 0) begin
                    for (int t = e; t <= n; t++) begin
                        if (seg(star + 1, np, t) >= 0) begin m = 1'b1; idx = s; return; end
                    end
                end
            end
        end
    endfunction

    // ---------------- stimulus ----------------
    task automatic send(input bq_t s, input bit ws, input bq_t p, input bit nc);
        @(negedge clk);
        if (ws) begin
            foreach (s[i]) begin
                isstring = 1'b1;
                chardata = s[i];
                @(negedge clk);
            end
            isstring = 1'b0;
            m_str.delete();
            foreach (s[i]) if (i < int'(STR_DEPTH)) m_str.push_back(s[i]);
        end
        nocase = nc;
        foreach (p[i]) begin
            ispattern = 1'b1;
            chardata  = p[i];
            @(negedge clk);
        end
        ispattern = 1'b0;
        chardata  = 8'h00;
        m_pat.delete();
        foreach (p[i]) if (i < int'(PAT_DEPTH)) m_pat.push_back(p[i]);
        m_nocase = nc;
    endtask

    task automatic wait_result();
        bit prev_busy;
        prev_busy   = busy;
        o_got       = 1'b0;
        o_match     = 1'b0;
        o_idx       = '0;
        o_busy_edge = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (valid) begin
                o_got       = 1'b1;
                o_match     = match;
                o_idx       = match_index;
                o_busy_edge = prev_busy && !busy;
                break;
            end
            prev_busy = busy;
        end
    endtask

    task automatic job(input string s, input bit ws, input string p, input bit nc);
        send(s2q(s), ws, s2q(p), nc);
        wait_result();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset     = 1'b1;
        chardata  = 8'h00;
        isstring  = 1'b0;
        ispattern = 1'b0;
        nocase    = 1'b0;
        m_str.delete();
        @(negedge clk);
        checks++;
        if ({busy, valid, match, match_index} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%0d valid=%0d match=%0d idx=%0d, want all 0",
                     busy, valid, match, match_index);
        end
        reset = 1'b0;
    endtask

    task automatic test_literal();
        job("THIS IS A BOOK", 1'b1, "BOOK", 1'b0);
        checks++;
        if (!o_got || o_match !== 1'b1 || o_idx !== IDX_W'(10)) begin
            errors++;
            $display("FAIL literal_book: got valid=%0d match=%0d idx=%0d, want 1 1 10",
                     o_got, o_match, o_idx);
        end
        checks++;
        if (o_busy_edge !== 1'b1) begin
            errors++;
            $display("FAIL busy_falls_with_valid: got %0d, want 1", o_busy_edge);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || match !== 1'b1 || match_index !== IDX_W'(10)) begin
            errors++;
            $display("FAIL valid_one_cycle_hold: got valid=%0d match=%0d idx=%0d, want 0 1 10",
                     valid, match, match_index);
        end
    endtask

    task automatic test_anchors();
        string pats[3] = '{"^IS", "IS$", "^OOK"};
        bit    em[3]   = '{1'b1, 1'b1, 1'b0};
        int    ei[3]   = '{5, 2, 0};
        for (int k = 0; k < 3; k++) begin
            job("", 1'b0, pats[k], 1'b0);
            checks++;
            if (!o_got || o_match !== em[k] || o_idx !== IDX_W'(ei[k])) begin
                errors++;
                $display("FAIL anchor_%s: got valid=%0d match=%0d idx=%0d, want 1 %0d %0d",
                         pats[k], o_got, o_match, o_idx, em[k], ei[k]);
            end
        end
    endtask

    task automatic test_star();
        string pats[3] = '{"T*K", "B*T", "*"};
        bit    em[3]   = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            job("", 1'b0, pats[k], 1'b0);
            checks++;
            if (!o_got || o_match !== em[k] || o_idx !== '0) begin
                errors++;
                $display("FAIL star_%s: got valid=%0d match=%0d idx=%0d, want 1 %0d 0",
                         pats[k], o_got, o_match, o_idx, em[k]);
            end
        end
    endtask

    task automatic test_nocase();
        job("", 1'b0, "book", 1'b1);
        checks++;
        if (!o_got || o_match !== 1'b1 || o_idx !== IDX_W'(10)) begin
            errors++;
            $display("FAIL nocase_on: got valid=%0d match=%0d idx=%0d, want 1 1 10",
                     o_got, o_match, o_idx);
        end
        job("", 1'b0, "book", 1'b0);
        checks++;
        if (!o_got || o_match !== 1'b0 || o_idx !== '0) begin
            errors++;
            $display("FAIL nocase_off: got valid=%0d match=%0d idx=%0d, want 1 0 0",
                     o_got, o_match, o_idx);
        end
    endtask

    task automatic test_truncation();
        string s = "";
        for (int i = 0; i < int'(STR_DEPTH) + 3; i++) s = {s, "a"};
        job(s, 1'b1, "aa$", 1'b0);
        checks++;
        if (!o_got || o_match !== 1'b1 || o_idx !== IDX_W'(STR_DEPTH - 2)) begin
            errors++;
            $display("FAIL truncation: got valid=%0d match=%0d idx=%0d, want 1 1 %0d",
                     o_got, o_match, o_idx, STR_DEPTH - 2);
        end
    endtask

    task automatic test_busy_ignore();
        send(s2q("THIS IS A BOOK"), 1'b1, s2q("BOOK"), 1'b0);
        for (int c = 0; c < 5 && !busy; c++) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            isstring = 1'b1;
            chardata = 8'h58;
            @(negedge clk);
        end
        isstring = 1'b0;
        wait_result();
        checks++;
        if (!o_got || o_match !== 1'b1 || o_idx !== IDX_W'(10)) begin
            errors++;
            $display("FAIL busy_ignore_result: got valid=%0d match=%0d idx=%0d, want 1 1 10",
                     o_got, o_match, o_idx);
        end
        job("", 1'b0, "BOOK", 1'b0);
        checks++;
        if (!o_got || o_match !== 1'b1 || o_idx !== IDX_W'(10)) begin
            errors++;
            $display("FAIL busy_ignore_string_kept: got valid=%0d match=%0d idx=%0d, want 1 1 10",
                     o_got, o_match, o_idx);
        end
    endtask

    task automatic test_reset_mid();
        bit seen_valid = 1'b0;
        send(s2q("THIS IS A BOOK"), 1'b1, s2q("BOOK"), 1'b0);
        for (int c = 0; c < 5 && !busy; c++) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_busy: got busy=%0d, want 1", busy);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, valid, match, match_index} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got busy=%0d valid=%0d match=%0d idx=%0d, want 0",
                     busy, valid, match, match_index);
        end
        @(negedge clk);
        reset = 1'b0;
        m_str.delete();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (valid) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid) begin
            errors++;
            $display("FAIL reset_mid_no_valid: got valid pulse=1, want 0");
        end
        job("", 1'b0, "^$", 1'b0);
        checks++;
        if (!o_got || o_match !== 1'b1 || o_idx !== '0) begin
            errors++;
            $display("FAIL empty_string_anchors: got valid=%0d match=%0d idx=%0d, want 1 1 0",
                     o_got, o_match, o_idx);
        end
    endtask

    task automatic test_random();
        byte unsigned sa[4] = '{8'h61, 8'h62, 8'h20, 8'h41};
        byte unsigned pa[7] = '{8'h61, 8'h62, 8'h2E, 8'h5E, 8'h24, 8'h2A, 8'h41};
        for (int j = 0; j < 80; j++) begin
            bq_t s;
            bq_t p;
            bit  ws;
            bit  nc;
            bit  star_used;
            bit  em;
            int  ei;
            int  sl;
            int  pl;
            ws = ($urandom_range(0, 3) != 0);
            nc = $urandom_range(0, 1);
            sl = ($urandom_range(0, 4) == 0) ? $urandom_range(1, STR_DEPTH + 4)
                                              : $urandom_range(1, 10);
            pl = ($urandom_range(0, 5) == 0) ? $urandom_range(1, PAT_DEPTH + 2)
                                              : $urandom_range(1, 4);
            for (int i = 0; i < sl; i++) s.push_back(sa[$urandom_range(0, 3)]);
            star_used = 1'b0;
            for (int i = 0; i < pl; i++) begin
                byte unsigned c = pa[$urandom_range(0, 6)];
                if (c == 8'h2A && star_used) c = 8'h61;
                if (c == 8'h2A) star_used = 1'b1;
                p.push_back(c);
            end
            send(s, ws, p, nc);
            wait_result();
            model(em, ei);
            checks++;
            if (!o_got || o_match !== em || o_idx !== IDX_W'(ei)) begin
                errors++;
                $display("FAIL random_job_%0d: got valid=%0d match=%0d idx=%0d, want 1 %0d %0d",
                         j, o_got, o_match, o_idx, em, ei);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_literal();
        test_anchors();
        test_star();
        test_nocase();
        test_truncation();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
